// File: rtl/slow_bus_bridge.sv
// Translates CPU-side AS30/DS30/RW30 cycles into paced Amiga slow-bus AS20/DS20/RW20 cycles.
// Define BUS_TIMEOUT_EN to build the DSACK timeout that ends a stuck cycle with BERR.
module slow_bus_bridge #(
  parameter int SETUP_TICKS    = 1,
  parameter int MIN_IDLE_TICKS = 1,
  parameter int TIMEOUT_TICKS  = 255,
  parameter int TO_W           = 8
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        TICK,
  input  logic        SAMPLE,
  input  logic [31:0] A,
  input  logic [2:0]  FC,
  input  logic [1:0]  SIZ,
  input  logic        AS30,
  input  logic        DS30,
  input  logic        RW30,
  input  logic        INTCYCLE,
  input  logic [1:0]  DSACK,
  output tri          AS20,
  output tri          DS20,
  output tri          RW20,
  output logic [1:0]  DS30ACK,
  output logic        BERR,
  output logic        HALT,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_TERM = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [3:0] IDLE_MAX   = 4'(MIN_IDLE_TICKS);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_TICKS - 1);

  state_t     state;
  logic       as20_int;
  logic       ds20_int;
  logic       rw20_int;
  logic       berr_to;
  logic [3:0] idle_cnt;
  logic [3:0] idle_next;
  logic [3:0] setup_cnt;
  logic       fpuop;
  logic       req;
  logic       step;
  logic       ack_hit;
  logic       idle_ok;
  logic       to_fire;
  logic       unused_ok;

  assign unused_ok = ^{SIZ, A[31:20], A[15:0], DS30ACK};

  assign fpuop = (FC == 3'b111) && (A[19:16] == 4'b0010);
  assign req   = ~AS30 & INTCYCLE & ~fpuop;
  // A TICK coinciding with SAMPLE still counts, but may not move the state.
  assign step    = TICK & ~SAMPLE;
  // DSACK is qualified only on the SAMPLE strobe; any non-11 value ends the cycle.
  assign ack_hit = SAMPLE && (DSACK != 2'b11);

  always_comb begin
    idle_next = idle_cnt;
    if (TICK && as20_int && (idle_cnt < IDLE_MAX)) idle_next = idle_cnt + 4'd1;
  end

  // The TICK that completes the idle spacing may itself launch the next cycle.
  assign idle_ok = (idle_next == IDLE_MAX);

`ifdef BUS_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] to_cnt;

  // Late form catches a limit TICK that was swallowed by a coincident SAMPLE.
  assign to_fire = (step && (to_cnt == TO_LAST)) || (to_cnt >= TO_LIMIT);

  always_ff @(posedge CLKCPU) begin
    if (!RESET || (state == S_IDLE)) begin
      to_cnt <= '0;
    end else if (TICK && ((state == S_ADDR) || (state == S_WAIT))) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic [TO_W-1:0] unused_to;

  assign unused_to = TO_W'(TIMEOUT_TICKS);
  assign to_fire   = 1'b0;
`endif

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state     <= S_IDLE;
      as20_int  <= 1'b1;
      ds20_int  <= 1'b1;
      rw20_int  <= 1'b1;
      DS30ACK   <= 2'b11;
      berr_to   <= 1'b1;
      idle_cnt  <= IDLE_MAX;
      setup_cnt <= 4'd0;
    end else begin
      idle_cnt <= idle_next;
      if ((state != S_IDLE) && AS30) begin
        state    <= S_IDLE;
        as20_int <= 1'b1;
        ds20_int <= 1'b1;
        rw20_int <= 1'b1;
        DS30ACK  <= 2'b11;
        berr_to  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (step && req && idle_ok) begin
              state     <= S_ADDR;
              as20_int  <= 1'b0;
              rw20_int  <= RW30;
              idle_cnt  <= 4'd0;
              setup_cnt <= 4'd0;
              if (RW30 || (SETUP_TICKS == 0)) ds20_int <= 1'b0;
            end
          end
          S_ADDR: begin
            if (to_fire) begin
              state   <= S_ERR;
              berr_to <= 1'b0;
            end else if (!ds20_int) begin
              state <= S_WAIT;
            end else if (step) begin
              if (setup_cnt == SETUP_LAST) begin
                ds20_int <= 1'b0;
                state    <= S_WAIT;
              end else begin
                setup_cnt <= setup_cnt + 4'd1;
              end
            end
          end
          S_WAIT: begin
            if (ack_hit) begin
              DS30ACK <= DSACK;
              state   <= S_TERM;
            end else if (to_fire) begin
              state   <= S_ERR;
              berr_to <= 1'b0;
            end
          end
          S_TERM: begin
            state <= S_TERM;
          end
          S_ERR: begin
            if (TICK) begin
              as20_int <= 1'b1;
              ds20_int <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign AS20 = INTCYCLE ? as20_int : 1'bz;
  assign RW20 = INTCYCLE ? rw20_int : 1'bz;
  assign DS20 = INTCYCLE ? (ds20_int | DS30) : 1'bz;

  assign BERR      = (~AS30 & fpuop) ? 1'b0 : berr_to;
  assign HALT      = 1'b1;
  assign dbg_state = state;

endmodule

// File: doc/slow_bus_bridge.md
Name: slow_bus_bridge

Overview:
- Parametrised successor to the 68030-to-Amiga slow-bus cycle translator.
- Runs entirely in the CLKCPU domain; slow-bus timing comes from two one-cycle strobe inputs (TICK, SAMPLE) produced by the existing 14M edge detector.
- Adds configurable write setup, configurable inter-cycle idle spacing and a DSACK timeout that raises BERR.
- Sits between the CPU-side strobes and the Amiga AS/DS/RW/DSACK pins.

Parameters:
- SETUP_TICKS, 1, TICK strobes between AS20 and DS20 assertion on writes (range 0..15).
- MIN_IDLE_TICKS, 1, TICK strobes that must pass with AS20 negated before a new cycle may start (range 0..15).
- TIMEOUT_TICKS, 255, TICK strobes waited for DSACK before bus error (range 1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- CLKCPU  in  1  CPU clock; the only clock.
- RESET  in  1  synchronous active-low reset.
- TICK  in  1  one-CLKCPU pulse per slow-bus falling edge (drive edge).
- SAMPLE  in  1  one-CLKCPU pulse per slow-bus rising edge (sample edge).
- A  in  32  CPU address.
- FC  in  3  function code.
- SIZ  in  2  transfer size; not used for decode, kept for bus visibility.
- AS30, DS30, RW30  in  1 each  CPU strobes, active low; RW30 high = read.
- INTCYCLE  in  1  high = cycle targets the slow bus.
- DSACK  in  2  slow-bus acknowledge, active low.
- AS20, DS20, RW20  out (tristate)  1 each  slow-bus strobes.
- DS30ACK  out  2  acknowledge to CPU, active low.
- BERR  out  1  bus error to CPU, active low.
- HALT  out  1  constant 1.

Behaviour:
- Reset (RESET=0 at a CLKCPU edge): state IDLE; AS20_INT, DS20_INT, RW20_INT = 1; DS30ACK = 11; BERR = 1; idle counter preset to MIN_IDLE_TICKS; timeout counter = 0. Reset mid-cycle abandons the cycle with no acknowledge.
- FPUOP = (FC==111) & (A[19:16]==0010). While AS30=0 & FPUOP, BERR=0 combinationally and no slow cycle starts. Otherwise BERR is driven only by the timeout path.
- REQ = ~AS30 & INTCYCLE & ~FPUOP.
- Idle counter: increments on each TICK while AS20_INT=1, saturating at MIN_IDLE_TICKS; clears when AS20_INT asserts.
- IDLE -> ADDR: on a TICK with REQ=1 and idle counter == MIN_IDLE_TICKS. AS20_INT=0 and RW20_INT=RW30 on that edge. On reads, DS20_INT=0 on the same edge.
- ADDR -> WAIT:
  - Reads: immediately on the next cycle.
  - Writes: after SETUP_TICKS further TICKs, DS20_INT=0. With SETUP_TICKS=0, a write behaves like a read.
- WAIT: on SAMPLE with DSACK != 11, latch DS30ACK <= DSACK and go to TERM. The timeout counter increments on each TICK in ADDR/WAIT.
- TERM: DS30ACK held. When AS30 goes 1, go to IDLE within one CLKCPU: DS30ACK=11 and AS20_INT, DS20_INT, RW20_INT=1.
- Abort: AS30 going 1 in any non-IDLE state returns to IDLE on the next CLKCPU edge, with all outputs negated as in TERM exit.
- Simultaneous TICK and SAMPLE: SAMPLE is evaluated first. TICK still advances the counters, but no state transition other than the SAMPLE-driven one occurs.
- Pins:
  - AS20 = INTCYCLE ? AS20_INT : Z.
  - RW20 = INTCYCLE ? RW20_INT : Z.
  - DS20 = INTCYCLE ? (DS20_INT | DS30) : Z.
- Latency: AS20 asserts on the first eligible TICK after REQ. DS30ACK asserts 1 CLKCPU after the qualifying SAMPLE.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - Timeout counter reaching TIMEOUT_TICKS in ADDR/WAIT moves to ERR.
  - ERR: BERR=0 and DS30ACK=11. AS20_INT/DS20_INT negate on the next TICK. BERR holds until AS30=1, then IDLE.
- Undefined: no timeout counter is built, WAIT holds indefinitely, and BERR reflects FPUOP only.

Test Plan:
- Read: RESET low 2 cycles then high; AS30=0, RW30=1, INTCYCLE=1, FC=101, DSACK=10 at the 3rd SAMPLE -> AS20 and DS20 fall on the same TICK, DS30ACK=10 one CLKCPU after that SAMPLE, all negate within 1 CLKCPU after AS30 rises.
- Write with SETUP_TICKS=2: RW30=0 -> DS20 falls exactly 2 TICKs after AS20; RW20=0 throughout the cycle.
- Back-to-back with MIN_IDLE_TICKS=3: second AS30 assertion arrives 1 TICK after the first cycle ends -> AS20 reasserts only on the 3rd TICK after negation.
- FPU: FC=111, A[19:16]=0010, AS30=0 -> BERR=0, AS20 stays 1, DS30ACK=11.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_TICKS=4): DSACK=11 always -> BERR=0 after the 4th TICK, AS20 negates on the next TICK, BERR=1 after AS30 rises.
- Abort and tristate: AS30 raised in WAIT -> AS20/DS20=1 next CLKCPU. INTCYCLE=0 -> AS20/DS20/RW20 all Z.
